// File: rtl/xgmii_rx_stats_pkg.sv
// Shared XGMII receive definitions: setup macros, control characters and parser states.
`ifndef XGMII_SETUP_DEFINES
`define XGMII_SETUP_DEFINES
`define MAGIC_CODE  40'h5A_C3_96_3C_A5
`define XGMII_START 8'hFB
`define XGMII_TERM  8'hFD
`define XGMII_IDLE  8'h07
`endif

package xgmii_rx_stats_pkg;

    localparam logic [7:0]  XGMII_START     = `XGMII_START;
    localparam logic [7:0]  XGMII_TERM      = `XGMII_TERM;
    localparam logic [7:0]  XGMII_IDLE      = `XGMII_IDLE;
    localparam logic [16:0] MIN_FRAME_BYTES = 17'd64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } rx_state_e;

    function automatic logic [7:0] lane(input logic [63:0] word, input int n);
        return word[8*n +: 8];
    endfunction

endpackage

// File: rtl/xgmii_rx_stats_term_detect.sv
// Combinational terminate detector: flags an FD control byte and reports the lowest lane holding one.
module xgmii_term_detect
    import xgmii_rx_stats_pkg::*;
(
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic        term,
    output logic [2:0]  term_lane
);

    // Scanning from lane 7 down leaves the lowest matching lane as the final assignment.
    always_comb begin
        term      = 1'b0;
        term_lane = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rxc[i] && (rxd[8*i +: 8] == XGMII_TERM)) begin
                term      = 1'b1;
                term_lane = 3'(i);
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_stats.sv
// XGMII receive statistics: frame parsing, probe qualification, latency/IP capture
// and per-window frame and byte counters.
module xgmii_rx_stats
    import xgmii_rx_stats_pkg::*;
#(
    parameter logic [39:0] MAGIC   = `MAGIC_CODE,
    parameter logic [31:0] SAT_PPS = 32'hffffffff
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [31:0] rx_ipv4_ip
);

    rx_state_e   state;
    rx_state_e   state_next;
    logic [3:0]  word_idx;
    logic [15:0] byte_cnt;
    logic        probe_ok;
    logic [23:0] lat_cap;
    logic [31:0] ip_cap;
    logic [31:0] pps_acc;
    logic [31:0] byte_acc;

    logic        term;
    logic [2:0]  term_lane;
    logic        start;
    logic        in_data;
    logic [16:0] frame_bytes;
    logic [31:0] frame_bytes_ext;
    logic        commit_frame;
    logic        commit_probe;
    logic [32:0] byte_sum;
    logic [31:0] byte_next;
    logic [31:0] pps_next;
    logic        unused_gc;

    xgmii_term_detect u_term_detect (
        .rxd       (xgmii_rxd),
        .rxc       (xgmii_rxc),
        .term      (term),
        .term_lane (term_lane)
    );

    assign start           = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
    assign in_data         = (state == ST_RECV) && !start && (xgmii_rxc == 8'h00);
    assign frame_bytes     = {1'b0, byte_cnt} + {14'd0, term_lane};
    assign frame_bytes_ext = {15'd0, frame_bytes};
    assign commit_frame    = (state == ST_RECV) && !start && term && (frame_bytes >= MIN_FRAME_BYTES);
    assign commit_probe    = commit_frame && probe_ok;
    assign byte_sum        = {1'b0, byte_acc} + {1'b0, frame_bytes_ext};
    assign byte_next       = byte_sum[32] ? 32'hffffffff : byte_sum[31:0];
    assign pps_next        = (pps_acc >= SAT_PPS) ? SAT_PPS : pps_acc + 32'd1;
    assign unused_gc       = ^global_counter[31:24];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_next;
    end

    // A start character always wins, abandoning whatever frame was in progress.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_RECV;
        end else begin
            case (state)
                ST_RECV: begin
                    if (term)                      state_next = ST_IDLE;
                    else if (xgmii_rxc != 8'h00)   state_next = ST_DROP;
                end
                ST_DROP: if (term) state_next = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_idx <= '0;
            byte_cnt <= '0;
            probe_ok <= 1'b0;
            lat_cap  <= '0;
            ip_cap   <= '0;
        end else if (start) begin
            word_idx <= 4'd1;
            byte_cnt <= '0;
            probe_ok <= 1'b1;
        end else if (in_data) begin
            if (word_idx != 4'd15) word_idx <= word_idx + 4'd1;
            byte_cnt <= (byte_cnt > 16'hFFF7) ? 16'hFFFF : byte_cnt + 16'd8;
            case (word_idx)
                4'd2: if (lane(xgmii_rxd, 4) != 8'h08 || lane(xgmii_rxd, 5) != 8'h00 ||
                          lane(xgmii_rxd, 6) != 8'h45) probe_ok <= 1'b0;
                4'd3: if (lane(xgmii_rxd, 7) != 8'h11) probe_ok <= 1'b0;
                4'd4: ip_cap[31:16] <= {lane(xgmii_rxd, 6), lane(xgmii_rxd, 7)};
                4'd5: ip_cap[15:0]  <= {lane(xgmii_rxd, 0), lane(xgmii_rxd, 1)};
                4'd6: if ({lane(xgmii_rxd, 2), lane(xgmii_rxd, 3), lane(xgmii_rxd, 4),
                           lane(xgmii_rxd, 5), lane(xgmii_rxd, 6)} != MAGIC) probe_ok <= 1'b0;
                4'd7: lat_cap <= global_counter[23:0] -
                                 {lane(xgmii_rxd, 0), lane(xgmii_rxd, 1), lane(xgmii_rxd, 2)};
                default: ;
            endcase
        end
    end

    // A commit coinciding with the window pulse seeds the fresh accumulators instead of the old ones.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_pps        <= '0;
            rx_throughput <= '0;
            rx_latency    <= '0;
            rx_ipv4_ip    <= '0;
            pps_acc       <= '0;
            byte_acc      <= '0;
        end else begin
            if (commit_probe) begin
                rx_latency <= lat_cap;
                rx_ipv4_ip <= ip_cap;
            end
            if (sec_oneshot) begin
                rx_pps        <= pps_acc;
                rx_throughput <= byte_acc;
                pps_acc       <= (commit_probe && SAT_PPS != 32'd0) ? 32'd1 : 32'd0;
                byte_acc      <= commit_frame ? frame_bytes_ext : 32'd0;
            end else begin
                if (commit_probe) pps_acc  <= pps_next;
                if (commit_frame) byte_acc <= byte_next;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_rx_stats.sv
// Self-checking bench for xgmii_rx_stats: builds XGMII frames, models expected statistics in a scoreboard.
module tb_xgmii_rx_stats;

    localparam logic [39:0] TB_MAGIC  = 40'hC0_FF_EE_5A_17;
    localparam logic [63:0] IDLE_WORD = {8{8'h07}};

    typedef struct {
        logic [23:0] lat;
        logic [31:0] ip;
    } commit_exp_t;

    typedef struct {
        logic [31:0] pps;
        logic [31:0] thr;
    } window_exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        sec_oneshot;
    logic [31:0] global_counter;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [31:0] rx_pps;
    logic [31:0] rx_throughput;
    logic [23:0] rx_latency;
    logic [31:0] rx_ipv4_ip;

    commit_exp_t commit_q[$];
    window_exp_t window_q[$];

    logic [31:0] m_pps;
    logic [31:0] m_bytes;
    logic [23:0] m_lat;
    logic [31:0] m_ip;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    xgmii_rx_stats #(
        .MAGIC   (TB_MAGIC),
        .SAT_PPS (32'hffffffff)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_ipv4_ip     (rx_ipv4_ip)
    );

    // Drive one XGMII word at a falling edge; returns at the next falling edge, outputs settled.
    task automatic cycle(input logic [63:0] d, input logic [7:0] c, input logic osh,
                         input logic rst, input logic [31:0] gc);
        xgmii_rxd      = d;
        xgmii_rxc      = c;
        sec_oneshot    = osh;
        sys_rst        = rst;
        global_counter = gc;
        @(negedge sys_clk);
    endtask

    task automatic idle_cycle();
        cycle(IDLE_WORD, 8'hFF, 1'b0, 1'b0, global_counter);
    endtask

    // Window boundary on an idle word: the model snapshot is what the DUT must publish.
    task automatic pulse_window(input string name);
        window_exp_t we;
        we.pps = m_pps;
        we.thr = m_bytes;
        window_q.push_back(we);
        m_pps   = 32'd0;
        m_bytes = 32'd0;
        cycle(IDLE_WORD, 8'hFF, 1'b1, 1'b0, global_counter);
        we = window_q.pop_front();
        tests_run++;
        if (rx_pps !== we.pps) begin
            tests_failed++;
            $display("[TB] FAIL %s rx_pps: got %0d expected %0d", name, rx_pps, we.pps);
        end
        tests_run++;
        if (rx_throughput !== we.thr) begin
            tests_failed++;
            $display("[TB] FAIL %s rx_throughput: got %0d expected %0d", name, rx_throughput, we.thr);
        end
    endtask

    // Frame of full_words data words plus a terminate word with FD in lane 'lane'.
    task automatic send_frame(input string name, input int full_words, input int lane,
                              input bit probe_fmt, input bit bad_magic,
                              input logic [23:0] ts, input logic [31:0] arrival,
                              input logic [31:0] ip, input int ctrl_word,
                              input int rst_word, input int abort_word, input bit osh_on_term);
        logic [7:0]  fb [0:135];
        logic [63:0] d;
        logic [7:0]  c;
        logic [31:0] gc;
        logic [39:0] magic;
        commit_exp_t ce;
        window_exp_t we;
        int          nbytes;
        bit          good;
        bit          is_probe;

        nbytes = full_words * 8 + lane;
        for (int i = 0; i < 136; i++) fb[i] = 8'($urandom_range(0, 255));
        if (probe_fmt) begin
            fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'h11;
            fb[30] = ip[31:24]; fb[31] = ip[23:16]; fb[32] = ip[15:8]; fb[33] = ip[7:0];
            magic = TB_MAGIC;
            if (bad_magic) magic[23:16] = ~magic[23:16];
            for (int k = 0; k < 5; k++) fb[42 + k] = magic[39 - 8*k -: 8];
            fb[48] = ts[23:16]; fb[49] = ts[15:8]; fb[50] = ts[7:0];
        end else begin
            fb[12] = 8'h86;
        end

        for (int w = 0; w <= full_words + 1; w++) begin
            if (abort_word != 0 && w == abort_word) return;
            d = '0;
            c = '0;
            if (w == 0) begin
                d = {8'hD5, {6{8'h55}}, 8'hFB};
                c = 8'h01;
            end else if (w <= full_words) begin
                for (int n = 0; n < 8; n++) d[8*n +: 8] = fb[(w - 1) * 8 + n];
            end else begin
                for (int n = 0; n < 8; n++) begin
                    if (n < lane) begin
                        d[8*n +: 8] = fb[full_words * 8 + n];
                    end else if (n == lane) begin
                        d[8*n +: 8] = 8'hFD;
                        c[n] = 1'b1;
                    end else begin
                        d[8*n +: 8] = 8'h07;
                        c[n] = 1'b1;
                    end
                end
            end
            if (ctrl_word != 0 && w == ctrl_word) begin
                d[31:24] = 8'hFE;
                c[3]     = 1'b1;
            end
            gc = arrival - 32'd7 + 32'(w);

            if (w == full_words + 1) begin
                good     = (ctrl_word == 0) && (rst_word == 0) && (nbytes >= 64);
                is_probe = good && probe_fmt && !bad_magic;
                if (osh_on_term) begin
                    we.pps = m_pps;
                    we.thr = m_bytes;
                    window_q.push_back(we);
                    m_pps   = is_probe ? 32'd1 : 32'd0;
                    m_bytes = good ? 32'(nbytes) : 32'd0;
                end else begin
                    if (is_probe) m_pps = m_pps + 32'd1;
                    if (good)     m_bytes = m_bytes + 32'(nbytes);
                end
                if (is_probe) begin
                    m_lat = arrival[23:0] - ts;
                    m_ip  = ip;
                end
                ce.lat = m_lat;
                ce.ip  = m_ip;
                commit_q.push_back(ce);
                cycle(d, c, osh_on_term, 1'b0, gc);
                ce = commit_q.pop_front();
                tests_run++;
                if (rx_latency !== ce.lat) begin
                    tests_failed++;
                    $display("[TB] FAIL %s rx_latency: got %h expected %h", name, rx_latency, ce.lat);
                end
                tests_run++;
                if (rx_ipv4_ip !== ce.ip) begin
                    tests_failed++;
                    $display("[TB] FAIL %s rx_ipv4_ip: got %h expected %h", name, rx_ipv4_ip, ce.ip);
                end
                if (osh_on_term) begin
                    we = window_q.pop_front();
                    tests_run++;
                    if (rx_pps !== we.pps) begin
                        tests_failed++;
                        $display("[TB] FAIL %s coincident rx_pps: got %0d expected %0d", name, rx_pps, we.pps);
                    end
                    tests_run++;
                    if (rx_throughput !== we.thr) begin
                        tests_failed++;
                        $display("[TB] FAIL %s coincident rx_throughput: got %0d expected %0d",
                                 name, rx_throughput, we.thr);
                    end
                end
            end else if (rst_word != 0 && w == rst_word) begin
                cycle(d, c, 1'b0, 1'b1, gc);
                m_pps = '0; m_bytes = '0; m_lat = '0; m_ip = '0;
                tests_run++;
                if (rx_pps !== 32'd0 || rx_throughput !== 32'd0 || rx_latency !== 24'd0 || rx_ipv4_ip !== 32'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s mid-frame reset outputs: got %h/%h/%h/%h expected all zero",
                             name, rx_pps, rx_throughput, rx_latency, rx_ipv4_ip);
                end
            end else begin
                cycle(d, c, 1'b0, 1'b0, gc);
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(IDLE_WORD, 8'hFF, 1'b0, 1'b1, 32'd0);
        cycle(IDLE_WORD, 8'hFF, 1'b0, 1'b0, 32'd0);
        m_pps = '0; m_bytes = '0; m_lat = '0; m_ip = '0;
        tests_run++;
        if (rx_pps !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL reset rx_pps: got %h expected 0", rx_pps);
        end
        tests_run++;
        if (rx_throughput !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL reset rx_throughput: got %h expected 0", rx_throughput);
        end
        tests_run++;
        if (rx_latency !== 24'd0) begin
            tests_failed++; $display("[TB] FAIL reset rx_latency: got %h expected 0", rx_latency);
        end
        tests_run++;
        if (rx_ipv4_ip !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL reset rx_ipv4_ip: got %h expected 0", rx_ipv4_ip);
        end
    endtask

    task automatic test_latency();
        send_frame("latency_basic", 10, 0, 1, 0, 24'h000100, 32'h00000164, 32'h0A001569, 0, 0, 0, 0);
        tests_run++;
        if (rx_latency !== 24'h000064) begin
            tests_failed++; $display("[TB] FAIL latency_basic const: got %h expected 000064", rx_latency);
        end
        send_frame("latency_wrap", 10, 0, 1, 0, 24'hFFFFF0, 32'h01000010, 32'hC0A80001, 0, 0, 0, 0);
        tests_run++;
        if (rx_latency !== 24'h000020) begin
            tests_failed++; $display("[TB] FAIL latency_wrap const: got %h expected 000020", rx_latency);
        end
        pulse_window("latency_window");
    endtask

    task automatic test_ip_magic();
        send_frame("ip_good", 10, 0, 1, 0, 24'h000200, 32'h00000300, 32'h0A001569, 0, 0, 0, 0);
        send_frame("ip_bad_magic", 10, 0, 1, 1, 24'h000300, 32'h00000500, 32'h0B0B0B0B, 0, 0, 0, 0);
        tests_run++;
        if (rx_ipv4_ip !== 32'h0A001569) begin
            tests_failed++; $display("[TB] FAIL ip_bad_magic const: got %h expected 0a001569", rx_ipv4_ip);
        end
        pulse_window("ip_window");
    endtask

    task automatic test_window();
        for (int i = 0; i < 3; i++)
            send_frame("window80", 10, 0, 1, 0, 24'(32'h10 * i), 32'h00000800 + 32'(i), 32'h0A000001 + 32'(i), 0, 0, 0, 0);
        pulse_window("window80");
        tests_run++;
        if (rx_pps !== 32'd3 || rx_throughput !== 32'd240) begin
            tests_failed++;
            $display("[TB] FAIL window80 const: got %0d/%0d expected 3/240", rx_pps, rx_throughput);
        end
        for (int i = 0; i < 3; i++)
            send_frame("window_lane4", 9, 4, 1, 0, 24'h000400, 32'h00000A00 + 32'(i), 32'h0A000010 + 32'(i), 0, 0, 0, 0);
        pulse_window("window_lane4");
    endtask

    task automatic test_drop();
        send_frame("drop_good", 10, 0, 1, 0, 24'h000010, 32'h00001000, 32'h0A0000AA, 0, 0, 0, 0);
        send_frame("drop_ctrl", 10, 0, 1, 0, 24'h000010, 32'h00001100, 32'h0A0000BB, 4, 0, 0, 0);
        send_frame("drop_runt63", 7, 7, 1, 0, 24'h000010, 32'h00001200, 32'h0A0000CC, 0, 0, 0, 0);
        send_frame("drop_min64", 8, 0, 1, 0, 24'h000010, 32'h00001300, 32'h0A0000DD, 0, 0, 0, 0);
        pulse_window("drop_window");
        tests_run++;
        if (rx_throughput !== 32'd144) begin
            tests_failed++; $display("[TB] FAIL drop_window const: got %0d expected 144", rx_throughput);
        end
    endtask

    task automatic test_back_to_back();
        send_frame("coincident", 10, 0, 1, 0, 24'h000050, 32'h00002000, 32'h0A000101, 0, 0, 0, 1);
        send_frame("aborted", 10, 0, 1, 0, 24'h000060, 32'h00002100, 32'h0A000202, 0, 0, 6, 0);
        send_frame("after_abort", 10, 0, 1, 0, 24'h000070, 32'h00002200, 32'h0A000303, 0, 0, 0, 0);
        pulse_window("b2b_window");
        tests_run++;
        if (rx_pps !== 32'd2) begin
            tests_failed++; $display("[TB] FAIL b2b_window const: got %0d expected 2", rx_pps);
        end
    endtask

    task automatic test_reset_mid();
        send_frame("reset_mid", 10, 0, 1, 0, 24'h000080, 32'h00003000, 32'h0A000404, 0, 5, 0, 0);
        send_frame("after_reset", 10, 0, 1, 0, 24'h000090, 32'h00003100, 32'h0A000505, 0, 0, 0, 0);
        pulse_window("reset_window");
        tests_run++;
        if (rx_pps !== 32'd1) begin
            tests_failed++; $display("[TB] FAIL reset_window const: got %0d expected 1", rx_pps);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sys_rst        = 1'b1;
        sec_oneshot    = 1'b0;
        global_counter = 32'd0;
        xgmii_rxd      = IDLE_WORD;
        xgmii_rxc      = 8'hFF;
        test_reset();
        test_latency();
        test_ip_magic();
        test_window();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
